// File: rtl/prescaled_updown_counter_pkg.sv
// Shared definitions for the prescaled up/down counter.
//   - dir_e / mode_e : encodings of the up and sat_mode inputs
//   - clog2          : ceiling log2 of a positive value
//   - cnt_width      : register width for a 0..n-1 counter, minimum 1 bit
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic int unsigned clog2(input longint unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            if ((64'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned cnt_width(input longint unsigned value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/prescaled_updown_counter_tick_prescaler.sv
// Free-running prescaler that emits one tick every PRESCALE enabled cycles.
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-high reset (counter to 0, tick forced low)
//   enable in  1: counter advances; 0: counter holds its progress
//   clear  in  synchronous restart of the counter at 0
//   tick   out enable & (counter == PRESCALE-1), combinational
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned       PW   = cnt_width(PRESCALE);
    localparam logic [PW-1:0]     LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre_cnt;
    logic          w_last;

    assign w_last = (r_pre_cnt == LAST);
    // Gated by reset so PRESCALE=1 (tick=enable) still reads 0 during reset.
    assign tick   = enable & w_last & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_cnt <= '0;
        end else if (clear) begin
            r_pre_cnt <= '0;
        end else if (enable) begin
            r_pre_cnt <= w_last ? '0 : r_pre_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/prescaled_updown_counter.sv
// Parametrised up/down event counter with prescaler, programmable range,
// wrap/saturate mode and a registered terminal-count strobe.
//   clk        in  clock, rising edge
//   reset      in  asynchronous active-high reset
//   enable     in  1: prescaler advances; 0: prescaler and count hold
//   load       in  synchronous load of load_value (clamped to the range)
//   load_value in  value to load
//   up         in  1: count up; 0: count down
//   sat_mode   in  0: wrap at limits; 1: saturate at limits
//   count      out current count value
//   tick       out prescaler strobe; a step occurs at the edge where tick=1
//   tc         out one-cycle pulse after a step taken from the limit
//   at_limit   out count sits at the limit in the current direction
module prescaled_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 10_000_000,
    parameter int unsigned LIMIT_LO = 0,
    parameter int unsigned LIMIT_HI = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc,
    output logic             at_limit
);

    if (LIMIT_LO >= LIMIT_HI) begin : g_err_range
        $error("LIMIT_LO must be below LIMIT_HI");
    end
    if (longint'(LIMIT_HI) > (longint'(1) << WIDTH) - 1) begin : g_err_width
        $error("LIMIT_HI does not fit in WIDTH bits");
    end
    if (PRESCALE < 1) begin : g_err_prescale
        $error("PRESCALE must be at least 1");
    end

    localparam logic [WIDTH-1:0] LO = WIDTH'(LIMIT_LO);
    localparam logic [WIDTH-1:0] HI = WIDTH'(LIMIT_HI);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             w_tick;
    logic [WIDTH-1:0] w_step_val;
    logic             w_step_lim;
    logic [WIDTH-1:0] w_load_val;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .clear (load),
        .tick  (w_tick)
    );

    always_comb begin
        w_load_val = load_value;
        if (load_value < LO) begin
            w_load_val = LO;
        end else if (load_value > HI) begin
            w_load_val = HI;
        end
    end

    // Limit is tested before any arithmetic so +1/-1 never leaves the range.
    always_comb begin
        w_step_val = r_count;
        w_step_lim = 1'b0;
        if (up == DIR_UP) begin
            if (r_count == HI) begin
                w_step_lim = 1'b1;
                w_step_val = (sat_mode == MODE_SAT) ? HI : LO;
            end else begin
                w_step_val = r_count + WIDTH'(1);
            end
        end else begin
            if (r_count == LO) begin
                w_step_lim = 1'b1;
                w_step_val = (sat_mode == MODE_SAT) ? LO : HI;
            end else begin
                w_step_val = r_count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= LO;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_val;
            r_tc    <= 1'b0;
        end else if (w_tick) begin
            r_count <= w_step_val;
            r_tc    <= w_step_lim;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count    = r_count;
    assign tc       = r_tc;
    assign tick     = w_tick;
    assign at_limit = (up & (r_count == HI)) | (~up & (r_count == LO));

endmodule

// File: tb/tb_prescaled_updown_counter.sv
module tb_prescaled_updown_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, ld, up, sat;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic       tk, tcq, al;

    logic       e1;
    logic [3:0] cnt1;
    logic       tk1, tc1, al1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prescaled_updown_counter #(
        .WIDTH(4), .PRESCALE(3), .LIMIT_LO(2), .LIMIT_HI(9)
    ) dut (
        .clk(clk), .reset(reset), .enable(en), .load(ld), .load_value(lv),
        .up(up), .sat_mode(sat), .count(cnt), .tick(tk), .tc(tcq), .at_limit(al)
    );

    prescaled_updown_counter #(
        .WIDTH(4), .PRESCALE(1), .LIMIT_LO(2), .LIMIT_HI(9)
    ) dut1 (
        .clk(clk), .reset(reset), .enable(e1), .load(1'b0), .load_value(4'd0),
        .up(1'b1), .sat_mode(1'b0), .count(cnt1), .tick(tk1), .tc(tc1), .at_limit(al1)
    );

    typedef struct {
        logic       en, ld;
        logic [3:0] lv;
        logic       up, sat;
        logic [3:0] ec;
        logic       et, etc, eal;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int e, input int l, input int v, input int u, input int s,
                       input int c, input int t, input int tcx, input int a);
        vec_t x;
        x.en = e[0]; x.ld = l[0]; x.lv = v[3:0]; x.up = u[0]; x.sat = s[0];
        x.ec = c[3:0]; x.et = t[0]; x.etc = tcx[0]; x.eal = a[0];
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle's inputs after the edge, then checks outputs at the
    // following negedge, i.e. before those inputs are clocked in.
    task automatic apply(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        en = v.en; ld = v.ld; lv = v.lv; up = v.up; sat = v.sat;
        @(negedge clk);
        chk($sformatf("vec%0d.count", idx), 32'(cnt), 32'(v.ec));
        chk($sformatf("vec%0d.tick", idx), 32'(tk), 32'(v.et));
        chk($sformatf("vec%0d.tc", idx), 32'(tcq), 32'(v.etc));
        chk($sformatf("vec%0d.at_limit", idx), 32'(al), 32'(v.eal));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t h;
        reset = 1'b1;
        en = 0; ld = 0; lv = 0; up = 0; sat = 0; e1 = 0;

        // Wrap up: 8 -> 9 -> 2, tc after the wrap
        add(1,1,8,1,0, 2,0,0,0);
        add(1,0,0,1,0, 8,0,0,0);
        add(1,0,0,1,0, 8,0,0,0);
        add(1,0,0,1,0, 8,1,0,0);
        add(1,0,0,1,0, 9,0,0,1);
        add(1,0,0,1,0, 9,0,0,1);
        add(1,0,0,1,0, 9,1,0,1);
        add(1,0,0,1,0, 2,0,1,0);
        add(1,0,0,1,0, 2,0,0,0);
        // Saturate up at 9 (load lands on a tick cycle), then turn down
        add(1,1,9,1,1, 2,1,0,0);
        add(1,0,0,1,1, 9,0,0,1);
        add(1,0,0,1,1, 9,0,0,1);
        add(1,0,0,1,1, 9,1,0,1);
        add(1,0,0,1,1, 9,0,1,1);
        add(1,0,0,1,1, 9,0,0,1);
        add(1,0,0,1,1, 9,1,0,1);
        add(1,0,0,1,1, 9,0,1,1);
        add(1,0,0,1,1, 9,0,0,1);
        add(1,0,0,1,1, 9,1,0,1);
        add(1,0,0,0,1, 9,0,1,0);
        add(1,0,0,0,1, 9,0,0,0);
        add(1,0,0,0,1, 9,1,0,0);
        add(1,0,0,0,1, 8,0,0,0);
        // Wrap down: 3 -> 2 -> 9
        add(1,1,3,0,0, 8,0,0,0);
        add(1,0,0,0,0, 3,0,0,0);
        add(1,0,0,0,0, 3,0,0,0);
        add(1,0,0,0,0, 3,1,0,0);
        add(1,0,0,0,0, 2,0,0,1);
        add(1,0,0,0,0, 2,0,0,1);
        add(1,0,0,0,0, 2,1,0,1);
        add(1,0,0,0,0, 9,0,1,0);
        // Load clamping and load on a tick cycle
        add(1,1,0,0,0, 9,0,0,0);
        add(1,1,12,0,0, 2,0,0,1);
        add(1,0,0,0,0, 9,0,0,0);
        add(1,0,0,0,0, 9,0,0,0);
        add(1,1,5,1,0, 9,1,0,1);
        add(1,0,0,1,0, 5,0,0,0);
        add(1,0,0,1,0, 5,0,0,0);
        add(1,0,0,1,0, 5,1,0,0);
        add(1,0,0,1,0, 6,0,0,0);
        // Enable gap keeps prescaler progress
        add(1,1,4,1,0, 6,0,0,0);
        add(1,0,0,1,0, 4,0,0,0);
        add(1,0,0,1,0, 4,0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0,1,0, 4,0,0,0);
        add(1,0,0,1,0, 4,1,0,0);
        add(1,0,0,1,0, 5,0,0,0);

        #3;
        chk("reset.count", 32'(cnt), 32'd2);
        chk("reset.tc", 32'(tcq), 32'd0);
        chk("reset.tick", 32'(tk), 32'd0);
        chk("reset.at_limit", 32'(al), 32'd1);
        chk("reset.count1", 32'(cnt1), 32'd2);
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Mid-prescale reset: count=6, pre_cnt=1
        h = '{en:1, ld:1, lv:6, up:1, sat:0, ec:5, et:0, etc:0, eal:0};
        apply(h, 100);
        h = '{en:1, ld:0, lv:0, up:1, sat:0, ec:6, et:0, etc:0, eal:0};
        apply(h, 101);
        @(posedge clk);
        #2;
        chk("prereset.count", 32'(cnt), 32'd6);
        reset = 1'b1;
        e1 = 1'b1;
        #1;
        chk("async_reset.count", 32'(cnt), 32'd2);
        chk("async_reset.tc", 32'(tcq), 32'd0);
        chk("async_reset.tick", 32'(tk), 32'd0);
        chk("async_reset.tick_p1", 32'(tk1), 32'd0);
        chk("async_reset.count_p1", 32'(cnt1), 32'd2);
        @(negedge clk);
        chk("held_reset.count", 32'(cnt), 32'd2);
        reset = 1'b0;
        #1;
        chk("release.tick_p1", 32'(tk1), 32'd1);
        chk("release.count_p1", 32'(cnt1), 32'd2);
        @(negedge clk);
        chk("rel1.count", 32'(cnt), 32'd2);
        chk("rel1.tick", 32'(tk), 32'd0);
        chk("rel1.count_p1", 32'(cnt1), 32'd3);
        @(negedge clk);
        chk("rel2.count", 32'(cnt), 32'd2);
        chk("rel2.tick", 32'(tk), 32'd1);
        chk("rel2.count_p1", 32'(cnt1), 32'd4);
        e1 = 1'b0;
        @(negedge clk);
        chk("rel3.count", 32'(cnt), 32'd3);
        chk("gap.count_p1", 32'(cnt1), 32'd4);
        chk("gap.tick_p1", 32'(tk1), 32'd0);
        e1 = 1'b1;
        @(negedge clk);
        chk("resume.count_p1", 32'(cnt1), 32'd5);
        chk("resume.tc_p1", 32'(tc1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
